// File: rtl/sdram_arbiter.sv
// Purpose     : two-port round-robin arbiter sharing one single-command sdram_controller
//               between the GPMC register port (port 0) and the DMA/capture port (port 1).
// Latency     : req sampled in IDLE -> ack/enable/sd_addr next cycle; sd_rd_ready sampled
//               -> rvalid/rdata next cycle.
// Backpressure: req is level-held until ack; a request arriving while busy waits in place.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   req/we/addr/wdata{0,1}            requester command inputs (held until ack)
//   ack/rdata/rvalid{0,1}             per-port capture pulse and read-data return
//   err, owner, busy                  watchdog abort pulse, current/last owner, not-IDLE flag
//   sd_addr, sd_wr_data, sd_*_enable  controller command side
//   sd_rd_data, sd_rd_ready, sd_ack, sd_busy   controller status side
module sdram_arbiter #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic                  err,
  output logic                  owner,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] sd_addr,
  output logic [DATA_WIDTH-1:0] sd_wr_data,
  output logic                  sd_wr_enable,
  output logic                  sd_rd_enable,
  input  logic [DATA_WIDTH-1:0] sd_rd_data,
  input  logic                  sd_rd_ready,
  input  logic                  sd_ack,
  input  logic                  sd_busy
);

  localparam int              CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TMO = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  we_q, we_d;
  logic                  owner_q, owner_d;
  logic                  busy_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic                  ack0_q, ack0_d, ack1_q, ack1_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                  err_q, err_d;
  logic                  grant, sel_we, capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;   // port 0 wins the first contention
      we_q      <= 1'b0;
      owner_q   <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      we_q      <= we_d;
      owner_q   <= owner_d;
      busy_q    <= (state_d != IDLE);
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    we_d      = we_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    wr_en_d   = wr_en_q;
    rd_en_d   = rd_en_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    err_d     = 1'b0;
    capture   = 1'b0;
    // Under contention the port that did not win last time goes next;
    // a lone requester always wins.
    grant     = (req0 && req1) ? ~last_q : req1;
    sel_we    = grant ? we1 : we0;

    if (state_q == IDLE) begin
      // sd_ack / sd_rd_ready seen here belong to nothing we issued: ignored.
      if (req0 || req1) begin
        state_d = ISSUE;
        cnt_d   = '0;
        last_d  = grant;
        owner_d = grant;
        we_d    = sel_we;
        addr_d  = grant ? addr1 : addr0;
        wdata_d = grant ? wdata1 : wdata0;
        wr_en_d = sel_we;
        rd_en_d = ~sel_we;
        ack0_d  = ~grant;
        ack1_d  = grant;
      end
    end else if (cnt_q == TMO) begin
      // Watchdog abort: drop the command, report, and let the bus go idle.
      err_d   = 1'b1;
      wr_en_d = 1'b0;
      rd_en_d = 1'b0;
      state_d = IDLE;
    end else begin
      cnt_d = cnt_q + 1'b1;
      case (state_q)
        ISSUE: begin
          if (sd_ack) begin
            wr_en_d = 1'b0;
            rd_en_d = 1'b0;
            if (we_q)             state_d = WAIT_WR;
            else if (sd_rd_ready) capture = 1'b1;   // data arrived with the ack
            else                  state_d = WAIT_RD;
          end
        end
        WAIT_RD: if (sd_rd_ready) capture = 1'b1;
        WAIT_WR: if (!sd_busy) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (capture) begin
      state_d = IDLE;
      if (owner_q) begin
        rdata1_d  = sd_rd_data;
        rvalid1_d = 1'b1;
      end else begin
        rdata0_d  = sd_rd_data;
        rvalid0_d = 1'b1;
      end
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign rvalid0      = rvalid0_q;
  assign rvalid1      = rvalid1_q;
  assign err          = err_q;
  assign owner        = owner_q;
  assign busy         = busy_q;
  assign sd_addr      = addr_q;
  assign sd_wr_data   = wdata_q;
  assign sd_wr_enable = wr_en_q;
  assign sd_rd_enable = rd_en_q;

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port round-robin arbiter that shares the single-command `sdram_controller` between two requesters: the GPMC register port (port 0) and a streaming DMA/capture engine (port 1). It serialises one read or write at a time onto the controller's enable/ack/busy/rd_ready handshake and routes read data back to the owning port. A watchdog aborts any transaction that stalls. It sits between the GPMC command logic in `top` and `sdram_controller`.

## Interface
- `ADDR_WIDTH`, 25, SDRAM byte address width
- `DATA_WIDTH`, 8, SDRAM data width
- `TIMEOUT`, 1023, max cycles a transaction may stay outside IDLE before abort (≥ 4)
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0` / `req1`  in  1  port request, held until the matching `ack`
- `we0` / `we1`  in  1  1 = write, 0 = read; qualified by `req`
- `addr0` / `addr1`  in  ADDR_WIDTH  transaction address
- `wdata0` / `wdata1`  in  DATA_WIDTH  write data
- `ack0` / `ack1`  out  1  one-cycle pulse: request captured
- `rdata0` / `rdata1`  out  DATA_WIDTH  read data, valid with `rvalid`
- `rvalid0` / `rvalid1`  out  1  one-cycle read-data pulse
- `err`  out  1  one-cycle pulse on watchdog abort
- `owner`  out  1  port owning the current or last transaction
- `busy`  out  1  high whenever state ≠ IDLE
- `sd_addr`  out  ADDR_WIDTH  drives controller `wr_addr` and `rd_addr`
- `sd_wr_data`  out  DATA_WIDTH  controller `wr_data`
- `sd_wr_enable` / `sd_rd_enable`  out  1  controller command strobes
- `sd_rd_data`  in  DATA_WIDTH  controller `rd_data`
- `sd_rd_ready`, `sd_ack`, `sd_busy`  in  1  controller status

## Operation
- States: IDLE, ISSUE, WAIT_RD, WAIT_WR.
- IDLE:
  - If any `req` is high, grant one port, latch its `we`/`addr`/`wdata` into `sd_addr`/`sd_wr_data`, set `owner`, and go to ISSUE.
  - Assert that port's `ack` and exactly one of `sd_rd_enable`/`sd_wr_enable`.
- Round-robin: if both request, the port ≠ `last_grant` wins. A single requester always wins. `last_grant` resets to 1, so port 0 wins the first contention.
- ISSUE:
  - Enable held until `sd_ack` is sampled high; enable is cleared at that edge.
  - Write: on `sd_ack`, go to WAIT_WR.
  - Read: on `sd_ack`, go to WAIT_RD. If `sd_rd_ready` is also high in that cycle, capture data and go directly to IDLE.
- WAIT_RD: on `sd_rd_ready`, latch `sd_rd_data` into the owner's `rdata`, pulse the owner's `rvalid`, go to IDLE.
- WAIT_WR: when `sd_busy` is sampled low, go to IDLE.
- Watchdog:
  - A $clog2(TIMEOUT+1)-bit counter clears on the IDLE→ISSUE transition and increments each cycle outside IDLE.
  - When it equals TIMEOUT: pulse `err`, clear both enables, go to IDLE. No `rvalid` is produced.
- `sd_rd_ready`/`sd_ack` sampled in IDLE are ignored (stale).
- Non-owner `rdata` holds its previous value.
- A request arriving while busy waits; `req` is level-sensitive, with no queueing beyond the held request.
- Reset (async, any state):
  - State → IDLE; all outputs 0, including `rdata0/1`, `sd_addr`, `sd_wr_data`, and `owner`.
  - `last_grant` → 1; counter → 0. An in-flight transaction is dropped silently.

## Timing
- All outputs are registered.
- Request sampled in IDLE at edge N → `ack`, enable, `sd_addr` valid in cycle N+1.
- `sd_ack` sampled at edge A → enable low from cycle A+1.
- `sd_rd_ready` sampled at edge R → `rvalid`/`rdata` valid in cycle R+1, state IDLE in R+1. A new request can be sampled at edge R+1, so the next enable rises in cycle R+2.
- Requester must drop or change `req` in the cycle after `ack` is seen. The arbiter does not resample `req` before returning to IDLE (minimum 2 cycles after `ack`).
- `err` is asserted in the cycle after the counter reaches TIMEOUT.

## Test plan
- Single read, port 0, addr 0x0001234: controller acks 2 cycles after the enable and returns 0xA5 on `rd_ready` 5 cycles later → `ack0` in N+1, `sd_rd_enable` high exactly until the ack edge, `rvalid0` with `rdata0`=0xA5 one cycle after `rd_ready`, `rdata1` stays 0.
- Single write, port 1, addr 0x1FFFFFF, data 0x3C: `sd_wr_enable` with `sd_addr`=0x1FFFFFF and `sd_wr_data`=0x3C until ack; `busy` falls one cycle after `sd_busy` is sampled low; no `rvalid`.
- Both ports request continuously with reads → grants alternate 0,1,0,1, first grant to port 0, each `rdata` routed to the correct port.
- Controller never asserts `sd_ack`, TIMEOUT=8 → `err` pulses once 9 cycles after the enable rises, enable drops, `busy` returns 0, the next request is accepted normally.
- Read with `sd_ack` and `sd_rd_ready` high in the same cycle, data 0x5A → `rvalid` the next cycle with 0x5A, no WAIT_RD cycle.
- `rst` pulsed mid-WAIT_RD → all outputs 0 immediately; a late `sd_rd_ready` after reset produces no `rvalid`; the next contention grants port 0.
